// File: rtl/vend_controller.sv
// Credit and dispense sequencer for the food machine: owns the customer balance, validates
// purchases from the menu, drives the dispenser with a timeout and pays change as unit pulses.
module vend_controller #(
    parameter int CREDIT_W     = 6,
    parameter int MAX_CREDIT   = 63,
    parameter int CHANGE_UNIT  = 5,
    parameter int DISP_TIMEOUT = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                buy_req,
    input  logic [3:0]          buy_item,
    input  logic [CREDIT_W-1:0] buy_price,
    input  logic                cancel,
    input  logic                disp_done,
    output logic [CREDIT_W-1:0] saldo,
    output logic                busy,
    output logic [3:0]          dispense,
    output logic                buy_ack,
    output logic                buy_nak,
    output logic                coin_reject,
    output logic                change_pulse,
    output logic                fault
);

    localparam int TIMER_W = $clog2(DISP_TIMEOUT + 1);
    localparam logic [CREDIT_W-1:0] ZERO_C   = {CREDIT_W{1'b0}};
    localparam logic [CREDIT_W-1:0] UNIT_C   = CREDIT_W'(CHANGE_UNIT);
    localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [TIMER_W-1:0]  TMO_LAST = TIMER_W'(DISP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Sum is one bit wider than the credit so an overflowing coin is caught rather than wrapped.
    function automatic logic coin_ok(input logic [CREDIT_W-1:0] bal, input logic [CREDIT_W-1:0] coin);
        logic [CREDIT_W:0] sum_v;
        sum_v = {1'b0, bal} + {1'b0, coin};
        return (coin != ZERO_C) && ((coin % UNIT_C) == ZERO_C) && (sum_v <= MAX_C);
    endfunction

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  saldo_q, saldo_d;
    logic [3:0]           item_q, item_d;
    logic [CREDIT_W-1:0]  price_q, price_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 busy_q, busy_d;
    logic [3:0]           dispense_q, dispense_d;
    logic                 ack_q, ack_d;
    logic                 nak_q, nak_d;
    logic                 rej_q, rej_d;
    logic                 chg_q, chg_d;
    logic                 fault_q, fault_d;

    // Next-state, credit bookkeeping and next values of the registered outputs
    always_comb begin
        state_d = state_q;
        saldo_d = saldo_q;
        item_d  = item_q;
        price_d = price_q;
        timer_d = timer_q;
        ack_d   = 1'b0;
        nak_d   = 1'b0;
        rej_d   = coin_valid;
        chg_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cancel) begin
                    rej_d = coin_valid;
                    if (saldo_q != ZERO_C) begin
                        state_d = ST_CHANGE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (buy_req) begin
                    rej_d   = coin_valid;
                    item_d  = buy_item;
                    price_d = buy_price;
                    state_d = ST_CHECK;
                end else if (coin_valid) begin
                    if (coin_ok(saldo_q, coin_value)) begin
                        rej_d   = 1'b0;
                        saldo_d = saldo_q + coin_value;
                    end else begin
                        rej_d = 1'b1;
                    end
                end else begin
                    rej_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (!is_onehot(item_q) || (price_q == ZERO_C) || (price_q > saldo_q)) begin
                    nak_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = {TIMER_W{1'b0}};
                    state_d = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                if (disp_done) begin
                    saldo_d = saldo_q - price_q;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_CHANGE: begin
                if (saldo_q == ZERO_C) begin
                    state_d = ST_IDLE;
                end else if (!chg_q) begin
                    // Saturating step so an odd remainder can never underflow the balance
                    chg_d   = 1'b1;
                    saldo_d = (saldo_q >= UNIT_C) ? (saldo_q - UNIT_C) : ZERO_C;
                end else begin
                    chg_d = 1'b0;
                end
            end
            ST_FAULT: begin
                if (cancel) begin
                    state_d = (saldo_q != ZERO_C) ? ST_CHANGE : ST_IDLE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d != ST_IDLE);
        dispense_d = (state_d == ST_DISPENSE) ? item_d : 4'b0000;
        fault_d    = (state_d == ST_FAULT);
    end

    // State, credit and output registers; credit held at reset is discarded
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            saldo_q    <= ZERO_C;
            item_q     <= 4'b0000;
            price_q    <= ZERO_C;
            timer_q    <= {TIMER_W{1'b0}};
            busy_q     <= 1'b0;
            dispense_q <= 4'b0000;
            ack_q      <= 1'b0;
            nak_q      <= 1'b0;
            rej_q      <= 1'b0;
            chg_q      <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            saldo_q    <= saldo_d;
            item_q     <= item_d;
            price_q    <= price_d;
            timer_q    <= timer_d;
            busy_q     <= busy_d;
            dispense_q <= dispense_d;
            ack_q      <= ack_d;
            nak_q      <= nak_d;
            rej_q      <= rej_d;
            chg_q      <= chg_d;
            fault_q    <= fault_d;
        end
    end

    assign saldo        = saldo_q;
    assign busy         = busy_q;
    assign dispense     = dispense_q;
    assign buy_ack      = ack_q;
    assign buy_nak      = nak_q;
    assign coin_reject  = rej_q;
    assign change_pulse = chg_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: stimulus queues expected output events, a negedge
// monitor pops and compares them; balance and level outputs are checked directly.
module tb_vend_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       coin_valid = 1'b0;
    logic [5:0] coin_value = 6'd0;
    logic       buy_req = 1'b0;
    logic [3:0] buy_item = 4'b0000;
    logic [5:0] buy_price = 6'd0;
    logic       cancel = 1'b0;
    logic       disp_done = 1'b0;
    logic [5:0] saldo;
    logic       busy;
    logic [3:0] dispense;
    logic       buy_ack, buy_nak, coin_reject, change_pulse, fault;

    vend_controller dut (
        .clock(clock), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
        .buy_req(buy_req), .buy_item(buy_item), .buy_price(buy_price), .cancel(cancel),
        .disp_done(disp_done), .saldo(saldo), .busy(busy), .dispense(dispense),
        .buy_ack(buy_ack), .buy_nak(buy_nak), .coin_reject(coin_reject),
        .change_pulse(change_pulse), .fault(fault)
    );

    always #5 clock = ~clock;

    typedef enum int {K_ACK, K_NAK, K_REJ, K_CHG, K_FLT} kind_t;
    typedef struct {
        kind_t kind;
        int    bal;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic fault_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic push(input kind_t k, input int b);
        exp_t e;
        e.kind = k;
        e.bal  = b;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input kind_t k);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual=%s/saldo=%0d required=none", k.name(), saldo);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.bal != int'(saldo)) begin
                failures++;
                $display("FAIL sb_event actual=%s/saldo=%0d required=%s/saldo=%0d",
                         k.name(), saldo, e.kind.name(), e.bal);
            end
        end
    endtask

    // Monitor: every output event observed at the falling edge must match the queue head
    always @(negedge clock) begin
        if (buy_ack)              sb_pop(K_ACK);
        if (buy_nak)              sb_pop(K_NAK);
        if (coin_reject)          sb_pop(K_REJ);
        if (change_pulse)         sb_pop(K_CHG);
        if (fault && !fault_prev) sb_pop(K_FLT);
        fault_prev <= fault;
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic coin(input logic [5:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        cyc();
        coin_valid = 1'b0;
        coin_value = 6'd0;
    endtask

    task automatic buy(input logic [3:0] item, input logic [5:0] price);
        buy_req   = 1'b1;
        buy_item  = item;
        buy_price = price;
        cyc();
        buy_req   = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int max_cyc);
        for (int i = 0; i < max_cyc && busy; i++) cyc();
        chk(nm, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] all_outs();
        return {16'd0, saldo, busy, dispense, buy_ack, buy_nak, coin_reject, change_pulse, fault};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        #23;
        chk("reset_outs", all_outs(), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_reset_outs", all_outs(), 32'd0);

        // Coins credited, odd coin returned
        coin(6'd25); coin(6'd10); coin(6'd5);
        chk("saldo_40", {26'd0, saldo}, 32'd40);
        push(K_REJ, 40);
        coin(6'd7);
        cyc();
        chk("saldo_after_7", {26'd0, saldo}, 32'd40);

        // Soda purchase delivered on the third dispense cycle
        push(K_ACK, 15);
        buy(4'b0001, 6'd25);
        chk("busy_check", {31'd0, busy}, 32'd1);
        chk("no_disp_in_check", {28'd0, dispense}, 32'd0);
        cyc(); chk("disp_c1", {28'd0, dispense}, 32'd1);
        cyc(); chk("disp_c2", {28'd0, dispense}, 32'd1);
        cyc(); chk("disp_c3", {28'd0, dispense}, 32'd1);
        disp_done = 1'b1;
        cyc();
        disp_done = 1'b0;
        chk("disp_off", {28'd0, dispense}, 32'd0);
        chk("saldo_15", {26'd0, saldo}, 32'd15);

        // Pizza too expensive: nak two cycles after the request, no dispense
        coin(6'd25);
        push(K_NAK, 40);
        buy(4'b1000, 6'd45);
        chk("nak_not_yet", {31'd0, buy_nak}, 32'd0);
        cyc();
        chk("no_disp_nak", {28'd0, dispense}, 32'd0);
        cyc();
        chk("saldo_after_nak", {26'd0, saldo}, 32'd40);

        // Credit ceiling, bad item, full refund of 60
        coin(6'd10); coin(6'd10);
        chk("saldo_60", {26'd0, saldo}, 32'd60);
        push(K_REJ, 60);
        coin(6'd5);
        push(K_NAK, 60);
        buy(4'b0110, 6'd5);
        cyc(); cyc();
        for (int b = 55; b >= 0; b -= 5) push(K_CHG, b);
        do_cancel();
        wait_idle("change60_done", 100);
        chk("saldo_0", {26'd0, saldo}, 32'd0);
        chk("sb_empty_t4", sb.size(), 32'd0);
        do_cancel();
        chk("cancel_zero_idle", {31'd0, busy}, 32'd0);

        // Torta at exact credit, dispenser never reports: timeout fault
        coin(6'd25); coin(6'd5);
        buy(4'b0010, 6'd30);
        cyc();
        chk("disp_torta", {28'd0, dispense}, 32'd2);
        push(K_FLT, 30);
        n = 0;
        while (!fault && n < 1100) begin
            cyc();
            n++;
        end
        chk("timeout_cycles", n, 32'd1000);
        chk("fault_level", {31'd0, fault}, 32'd1);
        chk("saldo_fault", {26'd0, saldo}, 32'd30);
        chk("disp_off_fault", {28'd0, dispense}, 32'd0);
        push(K_REJ, 30);
        coin(6'd10);
        buy(4'b0001, 6'd5);
        cyc();
        chk("fault_held", {31'd0, fault}, 32'd1);
        for (int b = 25; b >= 0; b -= 5) push(K_CHG, b);
        do_cancel();
        chk("fault_cleared", {31'd0, fault}, 32'd0);
        wait_idle("refund30_done", 100);
        chk("sb_empty_t5", sb.size(), 32'd0);

        // Asynchronous reset in the middle of a dispense
        coin(6'd10); coin(6'd10);
        buy(4'b0001, 6'd15);
        cyc();
        chk("disp_before_rst", {28'd0, dispense}, 32'd1);
        #2 reset = 1'b0;
        #1 chk("rst_mid_dispense", all_outs(), 32'd0);
        cyc();
        reset = 1'b1;

        // Asynchronous reset in the middle of paying change
        coin(6'd25);
        push(K_CHG, 20);
        do_cancel();
        cyc();
        #2 reset = 1'b0;
        #1 chk("rst_mid_change", all_outs(), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // cancel beats buy_req and coin in the same idle cycle
        coin(6'd10); coin(6'd10);
        push(K_REJ, 20);
        for (int b = 15; b >= 0; b -= 5) push(K_CHG, b);
        cancel     = 1'b1;
        buy_req    = 1'b1;
        buy_item   = 4'b0001;
        buy_price  = 6'd5;
        coin_valid = 1'b1;
        coin_value = 6'd5;
        cyc();
        cancel = 1'b0; buy_req = 1'b0; coin_valid = 1'b0;
        chk("combo_busy", {31'd0, busy}, 32'd1);
        chk("combo_saldo", {26'd0, saldo}, 32'd20);
        wait_idle("combo_done", 100);
        chk("combo_saldo_0", {26'd0, saldo}, 32'd0);
        cyc(); cyc();
        chk("sb_empty_end", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
